// File: rtl/vote_pkg.sv
// Shared definitions for the ballot collector and the majority voter stage.
//   N_VOTERS_DEF  : default ballots per word (also the majority block's width)
//   TIMEOUT_DEF   : default idle cycles in COLLECT before padding
//   PAD_VALUE_DEF : default value written into unfilled ballot positions
//   state_t       : collector state encoding
package vote_pkg;

    localparam int   N_VOTERS_DEF  = 4;
    localparam int   TIMEOUT_DEF   = 16;
    localparam logic PAD_VALUE_DEF = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/idle_timer.sv
// Idle timer for the ballot collector. Counts enabled cycles without a clear
// and pulses expire on the cycle the count reaches TIMEOUT-1 with no clear.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   enable : count only while high (collector in COLLECT); held at 0 otherwise
//   clear  : a ballot was accepted this cycle; restarts the count
//   expire : combinational pulse, timeout reached this cycle
module idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q, count_d;

    // A clear in the same cycle wins over expiry.
    assign expire = enable && !clear && (count_q == LAST);

    always_comb begin
        count_d = count_q + TW'(1);
        if (!enable || clear || expire) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vote_collector.sv
// Serial ballot collector feeding the majority voter's A input.
// Ballots arrive one bit at a time over valid/ready and are packed LSB-first
// into vote_word. A stalled voter is handled by an idle timeout that pads
// the remaining positions with PAD_VALUE.
//   clk, rst               : clock, asynchronous active-high reset
//   vote_valid/vote_bit    : ballot offer from upstream
//   vote_ready             : ballot can be accepted (low while a word is held)
//   word_valid/word_ready  : completed word handshake with the voter stage
//   vote_word              : assembled ballots, bit 0 = first accepted
//   vote_count             : number of real (non-padded) ballots
//   timed_out              : held word contains padded positions
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   ST_IDLE    | empty word, waiting for the first ballot
//   ST_COLLECT | partial word, idle timer running
//   ST_HOLD    | complete (or padded) word presented downstream
module vote_collector
    import vote_pkg::*;
#(
    parameter int   N_VOTERS  = N_VOTERS_DEF,
    parameter int   TIMEOUT   = TIMEOUT_DEF,
    parameter logic PAD_VALUE = PAD_VALUE_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vote_valid,
    input  logic                          vote_bit,
    output logic                          vote_ready,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [N_VOTERS-1:0]           vote_word,
    output logic [$clog2(N_VOTERS+1)-1:0] vote_count,
    output logic                          timed_out
);

    localparam int            CW       = $clog2(N_VOTERS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_VOTERS - 1);

    state_t              state_q, state_d;
    logic [N_VOTERS-1:0] word_q, word_d;
    logic [CW-1:0]       count_q, count_d;
    logic                to_q, to_d;
    logic                accept;
    logic                last;
    logic                expire;

    assign accept = vote_valid && vote_ready;
    // In IDLE count_q is 0, so this also covers the single-voter case.
    assign last   = (count_q == LAST_IDX);

    idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == ST_COLLECT),
        .clear  (accept),
        .expire (expire)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = last ? ST_HOLD : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    if (last) begin
                        state_d = ST_HOLD;
                    end
                end else if (expire) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (word_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state only, so they never depend on upstream inputs.
    always_comb begin
        vote_ready = (state_q != ST_HOLD);
        word_valid = (state_q == ST_HOLD);
    end

    // Word assembly. Expire is only ever raised in COLLECT without an accept.
    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        to_d    = to_q;
        if (state_q == ST_HOLD) begin
            if (word_ready) begin
                word_d  = '0;
                count_d = '0;
                to_d    = 1'b0;
            end
        end else if (accept) begin
            for (int i = 0; i < N_VOTERS; i++) begin
                if (CW'(i) == count_q) begin
                    word_d[i] = vote_bit;
                end
            end
            count_d = count_q + CW'(1);
        end else if (expire) begin
            for (int i = 0; i < N_VOTERS; i++) begin
                if (CW'(i) >= count_q) begin
                    word_d[i] = PAD_VALUE;
                end
            end
            to_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            count_q <= '0;
            to_q    <= 1'b0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
            to_q    <= to_d;
        end
    end

    assign vote_word  = word_q;
    assign vote_count = count_q;
    assign timed_out  = to_q;

endmodule

// File: doc/vote_collector.md
Name: vote_collector

Overview:
Upstream stage of the 4-bit majority voter. Accepts single-bit ballots serially over a valid/ready handshake and assembles them into an N_VOTERS-bit word. It presents that word, with a valid flag, to the majority block's A input. An idle timeout pads missing ballots so a stalled voter cannot block the voter stage forever.

Parameters:
N_VOTERS, 4, number of ballots per word; width of vote_word; must be >= 1.
TIMEOUT, 16, consecutive COLLECT-state cycles with no accepted ballot before padding; must be >= 2.
PAD_VALUE, 1'b0, value written into every unfilled bit position on timeout.

Ports:
clk  input  1  single system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
vote_valid  input  1  a ballot is offered on vote_bit.
vote_bit  input  1  ballot value.
vote_ready  output  1  collector can accept a ballot this cycle.
word_valid  output  1  vote_word is complete and stable.
word_ready  input  1  downstream consumes vote_word this cycle.
vote_word  output  N_VOTERS  assembled ballots; bit 0 is the first ballot accepted; drives majority A.
vote_count  output  $clog2(N_VOTERS+1)  number of real (non-padded) ballots in the current or held word.
timed_out  output  1  held word contains padded bits; valid only while word_valid=1.

Behaviour:
- Reset (rst=1, asynchronous, any state): state=IDLE; vote_word=0; vote_count=0; word_valid=0; timed_out=0; idle timer=0; vote_ready=1 once rst deasserts.
- Accept event: vote_valid & vote_ready sampled at a rising clk edge.
- States: IDLE, COLLECT, HOLD. Encoding lives in the package.
- IDLE: vote_ready=1, word_valid=0.
  - On accept: write vote_word[0], set vote_count=1.
  - Go to HOLD if N_VOTERS==1, else to COLLECT.
- COLLECT: vote_ready=1, word_valid=0.
  - On accept: write vote_word[vote_count], increment vote_count, clear the idle timer.
  - When the accept brings vote_count to N_VOTERS, go to HOLD at that edge.
- Latency: word_valid rises in the cycle right after the edge that accepts the last ballot. vote_word is combinationally stable from that cycle on.
- Idle timer: counts COLLECT cycles with no accept.
  - If the timer equals TIMEOUT-1 and no accept occurs that cycle, set bits [N_VOTERS-1:vote_count] to PAD_VALUE, set timed_out=1, and go to HOLD.
  - vote_count keeps the real ballot count.
- Simultaneous accept on the timeout cycle: the accept wins. The ballot is stored and the timer clears; padding occurs only if that ballot was not the last.
- HOLD: vote_ready=0 (ballots stall upstream); word_valid=1.
  - vote_word, vote_count and timed_out are held constant.
  - When word_ready=1 at an edge, go to IDLE and clear vote_word, vote_count and timed_out.
  - No ballot is accepted in the release cycle. The earliest next accept is one cycle after word_valid falls.
- word_ready while not in HOLD has no effect.
- vote_valid while vote_ready=0 has no effect. The ballot stays pending upstream; it is not lost or duplicated.
- IDLE never times out. The timer is held at 0 outside COLLECT.
- Reset asserted mid-COLLECT or mid-HOLD discards the partial or held word. No output glitches to an intermediate value after reset.
- Timer width: $clog2(TIMEOUT). All counters saturate-free by construction.

Decomposition:
- Shared package vote_pkg holds:
  - N_VOTERS default (4), shared with majority_4bit;
  - state encoding constants ST_IDLE, ST_COLLECT, ST_HOLD;
  - PAD_VALUE default.
- One natural sub-module: idle_timer.
  - Inputs: clk, rst, enable (state==COLLECT), clear (accept).
  - Output: expire pulse when count==TIMEOUT-1 with no clear.
  - Parameter: TIMEOUT.

Test Plan:
1. Reset then ballots 1,0,1,1 on four consecutive cycles, word_ready=0 -> word_valid=1 on cycle 5, vote_word=4'b1101, vote_count=4, timed_out=0, vote_ready=0; held stable for 10 cycles.
2. From scenario 1, pulse word_ready=1 for one cycle -> next cycle word_valid=0, vote_word=0, vote_count=0, vote_ready=1. A ballot offered during the release cycle is accepted one cycle later as bit 0.
3. Ballots 1,1, then vote_valid=0 for 16 cycles (TIMEOUT=16) -> word_valid=1, vote_word=4'b0011, vote_count=2, timed_out=1. With PAD_VALUE=1 the same stimulus gives vote_word=4'b1111.
4. Ballots 1,0,1, idle 15 cycles, then ballot 1 on the 16th idle cycle -> no timeout, vote_word=4'b1101, timed_out=0.
5. Ballots 1,1 accepted, assert rst asynchronously mid-cycle -> outputs clear before the next edge; then ballots 0,0,0,1 -> vote_word=4'b1000, with no remnant of the earlier ballots.
6. Sweep all 16 ballot patterns through vote_collector into majority_4bit with random word_ready back-pressure -> every word matches its ballot sequence, no ballot lost or duplicated, and Y matches the majority of each word.
